// File: rtl/branch_unit.sv
// Branch condition evaluator: registers taken flag and redirect target 1 cycle after inputs.
// No enable or handshake; the result of the current inputs is captured on every clk edge.
module branch_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [2:0]      branchType,
  input  logic [XLEN-1:0] jumpAddr,
  output logic            takeBranch,
  output logic [XLEN-1:0] branchTarget
);

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_JUMP = 3'b010,
    BR_NONE = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } branchTypeE;

  logic isEqual;
  logic isLessSigned;
  logic isLessUnsigned;
  logic condTrue;

  assign isEqual        = (operandA == operandB);
  assign isLessSigned   = ($signed(operandA) < $signed(operandB));
  assign isLessUnsigned = (operandA < operandB);

  always_comb begin
    condTrue = 1'b0;
    unique case (branchTypeE'(branchType))
      BR_EQ:   condTrue = isEqual;
      BR_NE:   condTrue = !isEqual;
      BR_JUMP: condTrue = 1'b1;
      BR_NONE: condTrue = 1'b0;
      BR_LT:   condTrue = isLessSigned;
      BR_GE:   condTrue = !isLessSigned;
      BR_LTU:  condTrue = isLessUnsigned;
      BR_GEU:  condTrue = !isLessUnsigned;
      default: condTrue = 1'b0;
    endcase
  end

  // A not-taken result zeroes the target so stale addresses never leak downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takeBranch   <= 1'b0;
      branchTarget <= '0;
    end else begin
      takeBranch   <= condTrue;
      branchTarget <= condTrue ? jumpAddr : '0;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed boundary cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_branch_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [2:0]      branchType;
  logic [XLEN-1:0] jumpAddr;
  logic            takeBranch;
  logic [XLEN-1:0] branchTarget;

  int checks;
  int failures;

  branch_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .operandA     (operandA),
    .operandB     (operandB),
    .branchType   (branchType),
    .jumpAddr     (jumpAddr),
    .takeBranch   (takeBranch),
    .branchTarget (branchTarget)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: operands as mathematical integers, signed view by subtracting 2^32.
  function automatic bit refTaken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    bit r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
    sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
    case (t)
      3'd0: r = (ua == ub);
      3'd1: r = (ua != ub);
      3'd2: r = 1'b1;
      3'd3: r = 1'b0;
      3'd4: r = (sa < sb);
      3'd5: r = (sa >= sb);
      3'd6: r = (ua < ub);
      default: r = (ua >= ub);
    endcase
    return r;
  endfunction

  // Drive inputs away from the edge, then step one rising edge and settle.
  task automatic driveEdge(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] addr);
    branchType = t;
    operandA   = a;
    operandB   = b;
    jumpAddr   = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n      = 1'b1;
    branchType = 3'd2;
    operandA   = 32'd0;
    operandB   = 32'd0;
    jumpAddr   = 32'hDEAD_BEEF;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: got take=%b target=%h, want 0/00000000", takeBranch, branchTarget);
    end
    // JUMP inputs during reset must not leak through on an edge.
    @(posedge clk);
    #1;
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold: got take=%b target=%h, want 0/00000000", takeBranch, branchTarget);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release registers the current JUMP inputs.
    @(posedge clk);
    #1;
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL reset_release: got take=%b target=%h, want 1/deadbeef", takeBranch, branchTarget);
    end
  endtask

  task automatic test_beq;
    driveEdge(3'd0, 32'd10, 32'd20, 32'd100);
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL beq_not_taken: got take=%b target=%0d, want 0/0", takeBranch, branchTarget);
    end
    driveEdge(3'd0, 32'd10, 32'd10, 32'd100);
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'd100) begin
      failures++;
      $display("FAIL beq_taken: got take=%b target=%0d, want 1/100", takeBranch, branchTarget);
    end
  endtask

  task automatic test_signed_boundary;
    driveEdge(3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40);
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'h40) begin
      failures++;
      $display("FAIL blt_minint: got take=%b target=%h, want 1/00000040", takeBranch, branchTarget);
    end
    driveEdge(3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40);
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL bltu_minint: got take=%b target=%h, want 0/00000000", takeBranch, branchTarget);
    end
    driveEdge(3'd4, 32'hFFFF_FFFF, 32'd0, 32'h1234);
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'h1234) begin
      failures++;
      $display("FAIL blt_minus1: got take=%b target=%h, want 1/00001234", takeBranch, branchTarget);
    end
    driveEdge(3'd7, 32'hFFFF_FFFF, 32'd0, 32'h1234);
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'h1234) begin
      failures++;
      $display("FAIL bgeu_minus1: got take=%b target=%h, want 1/00001234", takeBranch, branchTarget);
    end
  endtask

  task automatic test_sweep_equal;
    logic [7:0] expSeq;
    logic [31:0] expTarget;
    expSeq = 8'b1010_0101; // bit i is the taken flag for code i
    for (int i = 0; i < 8; i++) begin
      driveEdge(3'(i), 32'd5, 32'd5, 32'h200);
      expTarget = expSeq[i] ? 32'h200 : 32'd0;
      checks++;
      if (takeBranch !== expSeq[i] || branchTarget !== expTarget) begin
        failures++;
        $display("FAIL sweep_equal code=%0d: got take=%b target=%h, want %b/%h",
                 i, takeBranch, branchTarget, expSeq[i], expTarget);
      end
    end
  endtask

  task automatic test_hold;
    driveEdge(3'd0, 32'd7, 32'd7, 32'hABC0);
    operandB = 32'd8;
    branchType = 3'd3;
    #3;
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'hABC0) begin
      failures++;
      $display("FAIL hold_between_edges: got take=%b target=%h, want 1/0000abc0", takeBranch, branchTarget);
    end
    @(posedge clk);
    #1;
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL hold_next_edge: got take=%b target=%h, want 0/00000000", takeBranch, branchTarget);
    end
  endtask

  task automatic test_reset_mid;
    driveEdge(3'd0, 32'd10, 32'd10, 32'd100);
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'd100) begin
      failures++;
      $display("FAIL mid_pre: got take=%b target=%0d, want 1/100", takeBranch, branchTarget);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (takeBranch !== 1'b0 || branchTarget !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got take=%b target=%0d, want 0/0", takeBranch, branchTarget);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (takeBranch !== 1'b1 || branchTarget !== 32'd100) begin
      failures++;
      $display("FAIL mid_release: got take=%b target=%0d, want 1/100", takeBranch, branchTarget);
    end
  endtask

  task automatic test_random;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] addr;
    bit          expTake;
    logic [31:0] expTarget;
    for (int n = 0; n < 300; n++) begin
      t    = 3'($urandom_range(0, 7));
      a    = $urandom;
      addr = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = a + 32'd1;
        default: b = $urandom;
      endcase
      expTake   = refTaken(t, a, b);
      expTarget = expTake ? addr : 32'd0;
      driveEdge(t, a, b, addr);
      checks++;
      if (takeBranch !== expTake || branchTarget !== expTarget) begin
        failures++;
        $display("FAIL random n=%0d type=%0d a=%h b=%h: got take=%b target=%h, want %b/%h",
                 n, t, a, b, takeBranch, branchTarget, expTake, expTarget);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_beq();
    test_signed_boundary();
    test_sweep_equal();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
